// File: rtl/stopwatch_lap.sv
// MM:SS.cc BCD stopwatch with up/down counting, preload, prescaler, lap freeze
// and terminal-count flags. Fully synchronous to clk; all outputs registered.
module stopwatch_lap #(
    parameter int PRESC_DIV = 1,
    parameter int MIN_WRAP  = 60
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic        mode_down,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        lap,
    output logic [23:0] disp,
    output logic        running,
    output logic        lap_hold,
    output logic        done,
    output logic        wrap,
    output logic        load_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int              PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC_DIV - 1);
    localparam logic [3:0]      MAX_MH     = 4'((MIN_WRAP - 1) / 10);
    localparam logic [3:0]      MAX_ML     = 4'((MIN_WRAP - 1) % 10);
    localparam logic [7:0]      MAX_MIN    = {MAX_MH, MAX_ML};
    localparam logic [7:0]      MIN_LIM    = 8'(MIN_WRAP);
    localparam logic [23:0]     MAX_COUNT  = {MAX_MIN, 4'd5, 4'd9, 4'd9, 4'd9};

    // One digit of the carry chain: returns {digit, carry_out}
    function automatic logic [4:0] dig_up(input logic [3:0] d, input logic [3:0] top,
                                          input logic cin);
        if (!cin) begin
            return {d, 1'b0};
        end else if (d == top) begin
            return {4'd0, 1'b1};
        end else begin
            return {d + 4'd1, 1'b0};
        end
    endfunction

    function automatic logic [4:0] dig_dn(input logic [3:0] d, input logic [3:0] top,
                                          input logic bin);
        if (!bin) begin
            return {d, 1'b0};
        end else if (d == 4'd0) begin
            return {top, 1'b1};
        end else begin
            return {d - 4'd1, 1'b0};
        end
    endfunction

    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        {r[3:0], c}   = dig_up(v[3:0], 4'd9, c);
        {r[7:4], c}   = dig_up(v[7:4], 4'd9, c);
        {r[11:8], c}  = dig_up(v[11:8], 4'd9, c);
        {r[15:12], c} = dig_up(v[15:12], 4'd5, c);
        if (!c) begin
            r[23:16] = v[23:16];
        end else if (v[23:16] == MAX_MIN) begin
            r[23:16] = 8'h00;
        end else if (v[19:16] == 4'd9) begin
            r[23:16] = {v[23:20] + 4'd1, 4'd0};
        end else begin
            r[23:16] = {v[23:20], v[19:16] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        {r[3:0], b}   = dig_dn(v[3:0], 4'd9, b);
        {r[7:4], b}   = dig_dn(v[7:4], 4'd9, b);
        {r[11:8], b}  = dig_dn(v[11:8], 4'd9, b);
        {r[15:12], b} = dig_dn(v[15:12], 4'd5, b);
        if (!b) begin
            r[23:16] = v[23:16];
        end else if (v[23:16] == 8'h00) begin
            r[23:16] = MAX_MIN;
        end else if (v[19:16] == 4'd0) begin
            r[23:16] = {v[23:20] - 4'd1, 4'd9};
        end else begin
            r[23:16] = {v[23:20], v[19:16] - 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [23:0] v);
        logic [7:0] mv;
        mv = ({4'd0, v[23:20]} * 8'd10) + {4'd0, v[19:16]};
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) &&
               (v[15:12] <= 4'd5) && (v[19:16] <= 4'd9) && (v[23:20] <= 4'd9) &&
               (mv < MIN_LIM);
    endfunction

    state_t         state_r, state_nx_s;
    logic           dir_r, dir_nx_s;
    logic [PW-1:0]  presc_r, presc_nx_s;
    logic [23:0]    count_r, count_nx_s;
    logic [23:0]    lap_r, lap_nx_s;
    logic           lap_hold_r, lap_hold_nx_s;
    logic [23:0]    disp_r, disp_nx_s;
    logic           running_r, done_r, wrap_r, load_err_r;

    logic           tick_s, load_ok_s, load_good_s, load_bad_s, expire_s, wrap_s;
    logic           start_only_s;
    logic [23:0]    count_up_s, count_dn_s;

    assign tick_s       = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
    assign load_ok_s    = load && (state_r != ST_RUN);
    assign load_good_s  = load_ok_s && bcd_valid(load_val);
    assign load_bad_s   = load_ok_s && !bcd_valid(load_val);
    assign start_only_s = start && !stop;
    assign count_up_s   = bcd_inc(count_r);
    assign count_dn_s   = bcd_dec(count_r);
    // A down tick from 1 (or a degenerate 0) lands on zero and expires
    assign expire_s     = tick_s && dir_r &&
                          ((count_r == 24'h000001) || (count_r == 24'h000000));
    assign wrap_s       = tick_s && !dir_r && (count_r == MAX_COUNT);

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; an accepted load takes priority over start/stop
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_ok_s) begin
                    state_nx_s = ST_IDLE;
                end else if (start_only_s && !(mode_down && (count_r == 24'h000000))) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (expire_s) begin
                    state_nx_s = ST_EXPIRED;
                end else if (stop) begin
                    state_nx_s = ST_PAUSED;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (load_ok_s) begin
                    state_nx_s = ST_PAUSED;
                end else if (start_only_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_PAUSED;
                end
            end
            ST_EXPIRED: begin
                if (load_good_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_EXPIRED;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values
    always_comb begin
        presc_nx_s    = presc_r;
        count_nx_s    = count_r;
        lap_nx_s      = lap_r;
        lap_hold_nx_s = lap_hold_r;
        dir_nx_s      = dir_r;

        if ((state_r == ST_IDLE) && (state_nx_s == ST_RUN)) begin
            dir_nx_s = mode_down;
        end else begin
            dir_nx_s = dir_r;
        end

        if (load_good_s) begin
            presc_nx_s = {PW{1'b0}};
        end else if (state_r == ST_RUN) begin
            presc_nx_s = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
        end else begin
            presc_nx_s = presc_r;
        end

        if (load_good_s) begin
            count_nx_s = load_val;
        end else if (tick_s && dir_r) begin
            count_nx_s = expire_s ? 24'h000000 : count_dn_s;
        end else if (tick_s) begin
            count_nx_s = count_up_s;
        end else begin
            count_nx_s = count_r;
        end

        // Lap captures the pre-tick count; a second pulse releases the freeze
        if (load_good_s) begin
            lap_hold_nx_s = 1'b0;
        end else if (lap && (state_r != ST_IDLE)) begin
            if (lap_hold_r) begin
                lap_hold_nx_s = 1'b0;
            end else begin
                lap_hold_nx_s = 1'b1;
                lap_nx_s      = count_r;
            end
        end else begin
            lap_hold_nx_s = lap_hold_r;
        end

        disp_nx_s = lap_hold_nx_s ? lap_nx_s : count_nx_s;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dir_r      <= 1'b0;
            presc_r    <= {PW{1'b0}};
            count_r    <= 24'h000000;
            lap_r      <= 24'h000000;
            lap_hold_r <= 1'b0;
            disp_r     <= 24'h000000;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            dir_r      <= dir_nx_s;
            presc_r    <= presc_nx_s;
            count_r    <= count_nx_s;
            lap_r      <= lap_nx_s;
            lap_hold_r <= lap_hold_nx_s;
            disp_r     <= disp_nx_s;
            running_r  <= (state_nx_s == ST_RUN);
            done_r     <= expire_s;
            wrap_r     <= wrap_s;
            load_err_r <= load_bad_s;
        end
    end

    assign disp     = disp_r;
    assign running  = running_r;
    assign lap_hold = lap_hold_r;
    assign done     = done_r;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Scoreboard bench for stopwatch_lap: expectations are queued as stimulus is
// driven and popped one cycle later when the registered outputs are sampled.
module tb_stopwatch_lap;

    typedef logic [28:0] obs_t;

    logic        clk;
    logic        clr, start, stop, mode_down, load, lap;
    logic [23:0] load_val;

    logic [23:0] disp1, disp4;
    logic        running1, lap_hold1, done1, wrap1, load_err1;
    logic        running4, lap_hold4, done4, wrap4, load_err4;
    obs_t        o1, o4;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    stopwatch_lap #(.PRESC_DIV(1), .MIN_WRAP(60)) dut1 (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .mode_down(mode_down),
        .load(load), .load_val(load_val), .lap(lap), .disp(disp1),
        .running(running1), .lap_hold(lap_hold1), .done(done1), .wrap(wrap1),
        .load_err(load_err1)
    );

    stopwatch_lap #(.PRESC_DIV(4), .MIN_WRAP(60)) dut4 (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .mode_down(mode_down),
        .load(load), .load_val(load_val), .lap(lap), .disp(disp4),
        .running(running4), .lap_hold(lap_hold4), .done(done4), .wrap(wrap4),
        .load_err(load_err4)
    );

    assign o1 = {disp1, running1, lap_hold1, done1, wrap1, load_err1};
    assign o4 = {disp4, running4, lap_hold4, done4, wrap4, load_err4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t pk(input logic [23:0] d, input logic r, input logic h,
                                input logic dn, input logic w, input logic le);
        return {d, r, h, dn, w, le};
    endfunction

    // Integer centiseconds to MM:SS.cc BCD
    function automatic logic [23:0] to_bcd(input int n);
        int cs, s, m;
        cs = n % 100;
        s  = (n / 100) % 60;
        m  = (n / 6000) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic idle_inputs;
        start = 1'b0; stop = 1'b0; mode_down = 1'b0; load = 1'b0; lap = 1'b0;
        load_val = 24'h000000;
    endtask

    task automatic do_clr;
        @(negedge clk);
        idle_inputs();
        clr = 1'b1;
        #1 clr = 1'b0;
    endtask

    task automatic test_reset;
        obs_t got, e;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clr = (k < 2);
            start = (k < 2); load = (k < 2); lap = (k < 2); load_val = 24'h123456;
            if (k == 2) idle_inputs();
            exp_q.push_back(pk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(pk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                got = (d == 0) ? o1 : o4;
                e = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL reset step %0d dut%0d: got %h expected %h", k, d, got, e);
                end
            end
        end
    endtask

    task automatic test_count_up;
        obs_t got, e;
        do_clr();
        for (int k = 0; k <= 6000; k++) begin
            @(negedge clk);
            start = (k == 0);
            exp_q.push_back(pk(to_bcd(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            got = o1;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL count_up cycle %0d: got %h expected %h", k, got, e);
            end
        end
    endtask

    task automatic test_wrap;
        obs_t got, e;
        do_clr();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            idle_inputs();
            case (k)
                0: begin load = 1'b1; load_val = 24'h595999;
                         e = pk(24'h595999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
                1: begin start = 1'b1; e = pk(24'h595999, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
                2: e = pk(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                3: e = pk(24'h000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                default: e = pk(24'h000002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            exp_q.push_back(e);
            @(posedge clk); #1;
            got = o1;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wrap step %0d: got %h expected %h", k, got, e);
            end
        end
    endtask

    task automatic test_count_down;
        obs_t got, e;
        do_clr();
        for (int k = 0; k < 56; k++) begin
            @(negedge clk);
            idle_inputs();
            case (k)
                0: begin start = 1'b1; mode_down = 1'b1;           // zero count: ignored
                         e = pk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
                1: begin lap = 1'b1;                               // lap in IDLE ignored
                         e = pk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
                2: begin load = 1'b1; load_val = 24'h000002;
                         e = pk(24'h000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
                3: begin start = 1'b1; mode_down = 1'b1;
                         e = pk(24'h000002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
                4: e = pk(24'h000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                5: e = pk(24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                default: begin start = 1'b1;                       // EXPIRED ignores start
                         e = pk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
            endcase
            exp_q.push_back(e);
            @(posedge clk); #1;
            got = o1;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL count_down step %0d: got %h expected %h", k, got, e);
            end
        end
    endtask

    task automatic test_borrow;
        obs_t got, e;
        do_clr();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_inputs();
            case (k)
                0: begin load = 1'b1; load_val = 24'h010000;
                         e = pk(24'h010000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
                1: begin start = 1'b1; mode_down = 1'b1;
                         e = pk(24'h010000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
                2: e = pk(24'h005999, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                default: e = pk(24'h005998, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            exp_q.push_back(e);
            @(posedge clk); #1;
            got = o1;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL borrow step %0d: got %h expected %h", k, got, e);
            end
        end
    endtask

    // Divide-by-4 instance: stop lands with the prescaler parked at 2, so the
    // first tick after resume comes on the second edge following it.
    task automatic test_prescaler;
        obs_t got, e;
        logic [23:0] d;
        logic        r;
        do_clr();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            idle_inputs();
            start = (k == 0) || (k == 13);
            stop  = (k == 2);
            r = !((k >= 2) && (k <= 12));
            d = (k >= 19) ? 24'h000002 : ((k >= 15) ? 24'h000001 : 24'h000000);
            exp_q.push_back(pk(d, r, 1'b0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            got = o4;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL prescaler step %0d: got %h expected %h", k, got, e);
            end
        end
    endtask

    task automatic test_lap;
        obs_t got, e;
        logic hold_m;
        int   lap_m;
        hold_m = 1'b0;
        lap_m  = 0;
        do_clr();
        for (int k = 0; k <= 1250; k++) begin
            @(negedge clk);
            idle_inputs();
            start = (k == 0);
            lap   = (k == 1235) || (k == 1245);
            if (lap && !hold_m) begin
                hold_m = 1'b1;
                lap_m  = k - 1;
            end else if (lap) begin
                hold_m = 1'b0;
            end else begin
                hold_m = hold_m;
            end
            if (k >= 1230) begin
                exp_q.push_back(pk(hold_m ? to_bcd(lap_m) : to_bcd(k), 1'b1, hold_m,
                                   1'b0, 1'b0, 1'b0));
            end
            @(posedge clk); #1;
            if (k >= 1230) begin
                got = o1;
                e = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL lap cycle %0d: got %h expected %h", k, got, e);
                end
            end
        end
    endtask

    task automatic test_load;
        obs_t got, e;
        do_clr();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            idle_inputs();
            case (k)
                0: begin load = 1'b1; load_val = 24'h000500;
                         e = pk(24'h000500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
                1: begin start = 1'b1; e = pk(24'h000500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
                2: e = pk(24'h000501, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                3: e = pk(24'h000502, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                4: e = pk(24'h000503, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                5: begin stop = 1'b1; e = pk(24'h000504, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
                6: begin load = 1'b1; load_val = 24'h006100;
                         e = pk(24'h000504, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); end
                7: begin load = 1'b1; load_val = 24'h600000;
                         e = pk(24'h000504, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); end
                8: begin lap = 1'b1; e = pk(24'h000504, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); end
                9: begin load = 1'b1; load_val = 24'h001000;
                         e = pk(24'h001000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
                10: begin start = 1'b1; mode_down = 1'b1;          // resume keeps up
                          e = pk(24'h001000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
                11: e = pk(24'h001001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                12: begin load = 1'b1; load_val = 24'h000000;
                          e = pk(24'h001002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
                default: e = pk(24'h001003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            exp_q.push_back(e);
            @(posedge clk); #1;
            got = o1;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load step %0d: got %h expected %h", k, got, e);
            end
        end
        // Asynchronous clear while both instances run
        #2 clr = 1'b1;
        exp_q.push_back(pk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(pk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        for (int d = 0; d < 2; d++) begin
            got = (d == 0) ? o1 : o4;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL clr_mid_run dut%0d: got %h expected %h", d, got, e);
            end
        end
        #1 clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        idle_inputs();
        test_reset();
        test_count_up();
        test_wrap();
        test_count_down();
        test_borrow();
        test_prescaler();
        test_lap();
        test_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
Parametrised successor to the team's cascaded BCD stopwatch. It provides a 6-digit BCD time of MM:SS.cc (minutes, seconds, centiseconds). It adds up/down counting with preload, an on-chip prescaler, lap/split freeze of the display, and a terminal-count flag. The block is fully synchronous to one clock, with no ripple-clocked stages, and drives the 7-segment display mux.

Parameters:
PRESC_DIV, 1, clk cycles per centisecond tick (1..2^20); 1 means tick every cycle (simulation).
MIN_WRAP, 60, minutes modulus (2..100); minutes count 0..MIN_WRAP-1.

Ports:
clk  in  1  system clock, all flops posedge
clr  in  1  reset clr, asynchronous, active-high
start  in  1  level-sampled run request
stop  in  1  level-sampled pause request
mode_down  in  1  count direction, sampled only on IDLE->RUN (1 = down)
load  in  1  preload strobe
load_val  in  24  BCD {mh,ml,sh,sl,msh,msl}
lap  in  1  lap/split strobe (one-cycle pulse)
disp  out  24  BCD digits shown, same packing as load_val
running  out  1  state==RUN
lap_hold  out  1  disp is frozen lap value
done  out  1  one-cycle pulse, down count reached zero
wrap  out  1  one-cycle pulse, up count wrapped to zero
load_err  out  1  one-cycle pulse, rejected load

Behaviour:
- clr: count=0, lap register=0, prescaler=0, state IDLE, dir=up. All outputs 0.
- States: IDLE, RUN, PAUSED, EXPIRED.
  - IDLE+start goes to RUN and latches dir=mode_down.
  - RUN+stop goes to PAUSED.
  - PAUSED+start goes to RUN; dir is kept and mode_down is ignored.
  - RUN with down count reaching zero goes to EXPIRED.
  - Only a valid load leaves EXPIRED, going to IDLE. start in EXPIRED is ignored.
- start and stop in the same cycle: stop wins. In IDLE neither has any effect in that case.
- IDLE+start with mode_down=1 and count==0: start is ignored, state stays IDLE, done is not pulsed.
- Prescaler:
  - Increments only in RUN and holds in PAUSED, so resume keeps the phase.
  - It is cleared by clr or a valid load.
  - tick = RUN && prescaler==PRESC_DIV-1; the prescaler then returns to 0.
- Up count on tick, from least significant digit:
  - msl 0..9, then msh 0..9, giving centiseconds 00..99.
  - sl 0..9, then sh 0..5.
  - minutes 00..MIN_WRAP-1 as 2-digit BCD.
  - MIN_WRAP-1:59.99 goes to 00:00.00 with wrap=1 for that cycle; counting continues.
- Down count on tick:
  - Borrow chain is the mirror of up: 0 goes to 9 (or 5 for sh, MIN_WRAP-1 for minutes).
  - 00:00.01 goes to 00:00.00 on the same edge as done=1 and state EXPIRED. Count then holds 0.
- Count and disp update on the clk edge where tick is true. There is no extra latency.
- load:
  - Accepted only in IDLE, PAUSED or EXPIRED. In RUN it is ignored with no load_err.
  - Valid means all digits ≤9, sh≤5, and minutes value < MIN_WRAP.
  - Valid load: count=load_val, prescaler=0, and state becomes IDLE from EXPIRED; PAUSED stays PAUSED.
  - Invalid load: load_err=1 for one cycle, with count and state unchanged.
- lap (any state except IDLE):
  - lap_hold=0: lap register = current count (pre-tick value of that edge), lap_hold=1.
  - lap_hold=1: lap_hold=0 and the display returns to live. A new lap captures again on the next pulse.
  - lap in IDLE is ignored.
  - A valid load forces lap_hold=0.
- disp = lap_hold ? lap register : count.
- Counting is unaffected by lap.
- clr mid-operation overrides everything asynchronously. The first tick after release needs PRESC_DIV RUN cycles.

Test Plan:
1. PRESC_DIV=1: clr, start, run 6000 cycles -> disp=0x010000, running=1. At cycle 5999 disp=0x005999. No wrap.
2. MIN_WRAP=60: load 0x595999, start up, 1 tick -> disp=0x000000, wrap=1 for exactly one cycle, still RUN.
3. Load 0x000002, mode_down=1, start -> after 2 ticks disp=0x000000, done=1 for one cycle, state EXPIRED. 50 further cycles hold 0. start is ignored.
4. PRESC_DIV=4: run, stop at prescaler=2, hold 10 cycles, start -> next tick 2 cycles later, not 4.
5. Lap at live 0x001234 -> disp frozen at 0x001234, lap_hold=1 while live advances. Second lap -> disp=live value, lap_hold=0.
6. Paused, load 0x006100 -> load_err=1, count unchanged. load during RUN -> ignored, no load_err. Assert clr mid-RUN -> all outputs 0 immediately.
